counter_sequencer: RTL and testbench
====================================

// Module: counter_sequencer
// PURPOSE
//  Command-driven controller that sequences CounterModule: drives its control/init/initialValue inputs
//  from a queue of commands (op, optional preload, run length). Sits between software-/TB-level
//  stimulus and the counter; replaces hand-timed #delays with cycle-exact programmed sequences.
// PARAMETERS
//  COUNTER_SIZE  2  width of counter preload value (matches CounterModule counterSize)
//  DEPTH         4  command FIFO entries; power of 2, >=2
//  LEN_W         8  width of per-command run length
// PORTS
//  clk            in   1             single clock, all state on rising edge
//  rst            in   1             asynchronous, active-high reset
//  cmd_valid      in   1             command offered
//  cmd_ready      out  1             command accepted when valid&ready
//  cmd_op         in   2             counter control code for this command
//  cmd_load       in   1             1 = preload counter before running
//  cmd_value      in   COUNTER_SIZE  preload value
//  cmd_len        in   LEN_W         RUN cycles (0 treated as 1)
//  abort          in   1             synchronous flush of queue and current command
//  pause          in   1             freeze current command (only with SEQ_PAUSE_EN; else unused)
//  control        out  2             to CounterModule control
//  init           out  1             to CounterModule init
//  initial_value  out  COUNTER_SIZE  to CounterModule initialValue
//  busy           out  1             state != IDLE
//  done           out  1             1-cycle pulse per completed command
// BEHAVIOUR
//  - Control codes: 2'b00 HOLD, 2'b01 UP, 2'b10 DOWN, 2'b11 MODE3; cmd_op forwarded unchanged.
//  - Reset (async, immediate): control=00, init=0, initial_value=0, busy=0, done=0, FIFO empty, state IDLE.
//  - All outputs registered. cmd_ready = !fifo_full && !abort; no bypass when full (push+pop same cycle
//    while full: push refused).
//  - FSM IDLE/LOAD/RUN. IDLE with FIFO non-empty at edge t: pop head; at t+1 state LOAD if cmd_load
//    else RUN. Idle control=00, init=0.
//  - LOAD: exactly 1 cycle, init=1, initial_value=cmd_value, control=cmd_op; then RUN.
//  - RUN: control=cmd_op, init=0, for max(cmd_len,1) cycles; initial_value holds last loaded value.
//  - End of last RUN cycle: done=1 next cycle; if FIFO non-empty, next command's LOAD/RUN starts in that
//    same cycle (no gap); else IDLE with control=00.
//  - abort: next cycle control=00, init=0, FIFO emptied, IDLE; no done pulse; command offered in abort
//    cycle is not accepted. abort in IDLE just flushes FIFO.
//  - rst mid-command: state lost, outputs to reset values immediately; no done.
// CONFIGURATION
//  SEQ_PAUSE_EN defined: pause=1 in RUN forces control=00 and freezes remaining-length counter; resumes
//   same op on deassert; pause in LOAD delays the LOAD cycle; FIFO still accepts; abort overrides pause.
//  SEQ_PAUSE_EN undefined: pause port present but ignored; no pause logic synthesized.
// STRUCTURE
//  Package counter_seq_pkg: ctrl_t codes (CTRL_HOLD/UP/DOWN/MODE3), seq_state_t enum, cmd_t struct
//   {op, load, value, len} parameterised via package params.
//  Sub-module cmd_fifo: synchronous DEPTH-entry FIFO of cmd_t with full/empty, flush input.
// TESTING
//  1 rst=1 -> control=00, init=0, initial_value=0, cmd_ready=1, busy=0, done=0.
//  2 push {UP,load=1,value=2'b11,len=50} -> 1 cycle init=1/initial_value=3/control=01, 50 cycles control=01,
//    then done pulse, control=00, busy=0.
//  3 push {UP,0,-,3} then {DOWN,0,-,2} -> control 01,01,01,10,10,00 contiguous; two done pulses.
//  4 run {UP,0,-,200}, push 4 more -> cmd_ready=0 with FIFO full; 5th accepted one cycle after first pops.
//  5 abort at RUN cycle 10 of len 50 -> control=00 next cycle, FIFO empty, no done; len=0 cmd runs 1 cycle.
//  6 rst mid-RUN -> outputs reset immediately; with SEQ_PAUSE_EN, pause 5 cycles extends RUN by 5, control=00 meanwhile.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Package: counter_seq_pkg
// Shared types and sizing for counter_sequencer and its command FIFO.
//   COUNTER_SIZE : width of the counter preload value
//   DEPTH        : command FIFO entries (power of 2, >= 2)
//   LEN_W        : width of the per-command run length
//   ctrl_t       : CounterModule control codes
//   seq_state_t  : sequencer FSM states
//   cmd_t        : one queued command {op, load, value, len}
package counter_seq_pkg;

  localparam int unsigned COUNTER_SIZE = 2;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned LEN_W        = 8;

  typedef enum logic [1:0] {
    CTRL_HOLD  = 2'b00,
    CTRL_UP    = 2'b01,
    CTRL_DOWN  = 2'b10,
    CTRL_MODE3 = 2'b11
  } ctrl_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } seq_state_t;

  typedef struct packed {
    ctrl_t                   op;
    logic                    load;
    logic [COUNTER_SIZE-1:0] value;
    logic [LEN_W-1:0]        len;
  } cmd_t;

  // A zero length still runs for one cycle.
  function automatic logic [LEN_W-1:0] run_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

endpackage

// File: rtl/counter_sequencer_cmd_fifo.sv
// Module: cmd_fifo
// Synchronous FIFO of cmd_t commands with full/empty flags and a flush.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : synchronous clear of all entries (wins over push/pop)
//   push, push_data : write request; ignored while full (no bypass)
//   pop, pop_data   : read request; pop_data is the current head (valid when !empty)
//   full, empty : occupancy flags
module cmd_fifo
  import counter_seq_pkg::*;
#(
  parameter int unsigned Depth = DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  cmd_t            mem_q [Depth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] count_q;
  logic            push_ok, pop_ok;

  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PtrW'(1);
      if (pop_ok)  rd_q <= rd_q + PtrW'(1);
      if (push_ok && !pop_ok)      count_q <= count_q + CntW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CntW'(1);
    end
  end

  // Storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/counter_sequencer.sv
// Module: counter_sequencer
// Pulls commands from a small FIFO and drives CounterModule control/init/initialValue
// with cycle-exact sequences: optional 1-cycle LOAD, then RUN for max(len,1) cycles.
// Back-to-back commands run with no gap; done pulses once per completed command.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   cmd_valid/ready : command handshake; ready = !fifo_full && !abort
//   cmd_op, cmd_load, cmd_value, cmd_len : command fields
//   abort           : synchronous flush of queue and current command
//   pause           : freezes the current command (only with SEQ_PAUSE_EN)
//   control, init, initial_value : registered counter drive
//   busy            : FSM not idle
//   done            : 1-cycle pulse per completed command
// Build option: define SEQ_PAUSE_EN to enable pause; otherwise pause is ignored.
module counter_sequencer
  import counter_seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic                    cmd_load,
  input  logic [COUNTER_SIZE-1:0] cmd_value,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    abort,
  input  logic                    pause,
  output logic [1:0]              control,
  output logic                    init,
  output logic [COUNTER_SIZE-1:0] initial_value,
  output logic                    busy,
  output logic                    done
);

  cmd_t push_cmd, head_cmd;
  logic fifo_full, fifo_empty, fifo_push, fifo_pop;

  seq_state_t              state_q, state_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  ctrl_t                   op_q, op_d;
  logic [COUNTER_SIZE-1:0] val_q, val_d;
  ctrl_t                   control_q, control_d;
  logic                    init_q, init_d;
  logic [COUNTER_SIZE-1:0] ival_q, ival_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    paused_q, paused_d;
  logic                    pause_eff;
  logic                    start, active;

  assign cmd_ready = !fifo_full && !abort;
  assign fifo_push = cmd_valid && cmd_ready;
  assign push_cmd  = '{op: ctrl_t'(cmd_op), load: cmd_load, value: cmd_value, len: cmd_len};

  cmd_fifo #(
    .Depth(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort),
    .push     (fifo_push),
    .push_data(push_cmd),
    .pop      (fifo_pop),
    .pop_data (head_cmd),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef SEQ_PAUSE_EN
  // paused_q marks a frozen cycle: outputs idle, length counter held, state kept.
  assign pause_eff = pause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) paused_q <= 1'b0;
    else     paused_q <= paused_d;
  end
`else
  logic unused_pause;
  assign pause_eff    = 1'b0;
  assign paused_q     = 1'b0;
  assign unused_pause = pause ^ paused_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    val_d    = val_q;
    paused_d = 1'b0;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    start    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) start = 1'b1;
      end
      StLoad: begin
        paused_d = pause_eff;
        if (!paused_q) state_d = StRun;
      end
      StRun: begin
        if (paused_q) begin
          paused_d = pause_eff;
        end else if (cnt_q <= LEN_W'(1)) begin
          done_d = 1'b1;
          // Chain straight into the next command with no idle cycle.
          if (!fifo_empty) start = 1'b1;
          else             state_d = StIdle;
        end else begin
          cnt_d    = cnt_q - LEN_W'(1);
          paused_d = pause_eff;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      fifo_pop = 1'b1;
      state_d  = head_cmd.load ? StLoad : StRun;
      op_d     = head_cmd.op;
      val_d    = head_cmd.value;
      cnt_d    = run_len(head_cmd.len);
      paused_d = pause_eff;
    end

    if (abort) begin
      state_d  = StIdle;
      fifo_pop = 1'b0;
      done_d   = 1'b0;
      paused_d = 1'b0;
    end

    // Outputs are registered images of the next state.
    active    = (state_d != StIdle) && !paused_d;
    control_d = active ? op_d : CTRL_HOLD;
    init_d    = active && (state_d == StLoad);
    ival_d    = init_d ? val_d : ival_q;
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= CTRL_HOLD;
      val_q     <= '0;
      control_q <= CTRL_HOLD;
      init_q    <= 1'b0;
      ival_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      val_q     <= val_d;
      control_q <= control_d;
      init_q    <= init_d;
      ival_q    <= ival_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign control       = control_q;
  assign init          = init_q;
  assign initial_value = ival_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int OW = 5 + COUNTER_SIZE;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cmd_valid, cmd_ready, cmd_load, abort, pause;
  logic [1:0]              cmd_op;
  logic [COUNTER_SIZE-1:0] cmd_value;
  logic [LEN_W-1:0]        cmd_len;
  logic [1:0]              control;
  logic                    init, busy, done;
  logic [COUNTER_SIZE-1:0] initial_value;

  always #5 clk = ~clk;

  counter_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_load     (cmd_load),
    .cmd_value    (cmd_value),
    .cmd_len      (cmd_len),
    .abort        (abort),
    .pause        (pause),
    .control      (control),
    .init         (init),
    .initial_value(initial_value),
    .busy         (busy),
    .done         (done)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted command expands into a list of per-cycle output slots.
  typedef struct {
    logic [1:0]              op;
    logic                    load;
    logic [COUNTER_SIZE-1:0] value;
    logic [LEN_W-1:0]        len;
  } mcmd_t;

  typedef struct {
    logic [1:0]              ctrl;
    logic                    init;
    logic [COUNTER_SIZE-1:0] value;
    bit                      last;
  } slot_t;

  mcmd_t                   m_fifo[$];
  slot_t                   m_tl[$];
  logic                    m_done;
  logic [COUNTER_SIZE-1:0] m_iv;

  function automatic void model_reset();
    m_fifo.delete();
    m_tl.delete();
    m_done = 1'b0;
    m_iv   = '0;
  endfunction

  function automatic logic model_ready(input logic ab);
    return (m_fifo.size() < DEPTH) && !ab;
  endfunction

  function automatic void model_edge(input logic v, input logic [1:0] op, input logic ld,
                                     input logic [COUNTER_SIZE-1:0] val,
                                     input logic [LEN_W-1:0] len, input logic ab);
    bit    acc;
    mcmd_t c;
    int    n;
    acc = v && model_ready(ab);
    m_done = 1'b0;
    if (ab) begin
      m_fifo.delete();
      m_tl.delete();
    end else begin
      if (m_tl.size() > 0) begin
        if (m_tl[0].last) m_done = 1'b1;
        void'(m_tl.pop_front());
      end
      if (m_tl.size() == 0 && m_fifo.size() > 0) begin
        c = m_fifo.pop_front();
        if (c.load) m_tl.push_back('{ctrl: c.op, init: 1'b1, value: c.value, last: 1'b0});
        n = (c.len == 0) ? 1 : int'(c.len);
        for (int i = 0; i < n; i++)
          m_tl.push_back('{ctrl: c.op, init: 1'b0, value: '0, last: (i == n - 1)});
      end
      if (m_tl.size() > 0 && m_tl[0].init) m_iv = m_tl[0].value;
    end
    if (acc) m_fifo.push_back('{op: op, load: ld, value: val, len: len});
  endfunction

  function automatic logic [OW-1:0] model_out();
    if (m_tl.size() > 0) return {m_tl[0].ctrl, m_tl[0].init, m_iv, 1'b1, m_done};
    return {2'b00, 1'b0, m_iv, 1'b0, m_done};
  endfunction

  logic last_ready;

  // Inputs are applied 1 time unit after a rising edge; outputs sampled 1 unit after the next.
  task automatic cycle(input logic v, input logic [1:0] op, input logic ld,
                       input logic [COUNTER_SIZE-1:0] val, input logic [LEN_W-1:0] len,
                       input logic ab, input logic ps, input bit cmp);
    cmd_valid = v; cmd_op = op; cmd_load = ld; cmd_value = val; cmd_len = len;
    abort = ab; pause = ps;
    #1;
    last_ready = cmd_ready;
    if (cmp) check("cmd_ready", 32'(cmd_ready), 32'(model_ready(ab)));
    model_edge(v, op, ld, val, len, ab);
    @(posedge clk);
    #1;
    if (cmp) check("outputs", 32'({control, init, initial_value, busy, done}), 32'(model_out()));
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic idle(input bit cmp);
    cycle(1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b0, cmp);
  endtask

  typedef struct {
    logic             v;
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
    logic [1:0]       e_ctrl;
    logic             e_busy;
    logic             e_done;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n_ok, waits, n_zero, n_up;
    bit seen;

    // Back-to-back UP len3 then DOWN len2
    tbl[0] = '{1'b1, 2'b01, 8'd3, 2'b00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'b10, 8'd2, 2'b01, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 2'b00, 8'd0, 2'b01, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 2'b00, 8'd0, 2'b01, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 2'b00, 8'd0, 2'b10, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 2'b00, 8'd0, 2'b10, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 2'b00, 8'd0, 2'b00, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 2'b00, 8'd0, 2'b00, 1'b0, 1'b0};

    cmd_valid = 0; cmd_op = 0; cmd_load = 0; cmd_value = 0; cmd_len = 0;
    abort = 0; pause = 0;
    rst = 1'b1;
    model_reset();
    #3;
    check("reset_outputs", 32'({control, init, initial_value, busy, done}), 32'(0));
    check("reset_ready", 32'(cmd_ready), 32'(1));
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Load + long run
    cycle(1'b1, 2'b01, 1'b1, 2'b11, 8'd50, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("load_cycle", 32'({control, init, initial_value}), 32'({2'b01, 1'b1, 2'b11}));
    n_ok = 0;
    for (int i = 0; i < 50; i++) begin
      idle(1'b1);
      if (control == 2'b01 && !init && initial_value == 2'b11 && !done) n_ok++;
    end
    check("run_cycles", 32'(n_ok), 32'(50));
    idle(1'b1);
    check("run_end", 32'({done, busy, control}), 32'({1'b1, 1'b0, 2'b00}));
    idle(1'b1);
    check("done_pulse_1cyc", 32'(done), 32'(0));

    // Table-driven back-to-back sequence
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].v, tbl[i].op, 1'b0, '0, tbl[i].len, 1'b0, 1'b0, 1'b1);
      check($sformatf("seq_row%0d", i), 32'({control, init, busy, done}),
            32'({tbl[i].e_ctrl, 1'b0, tbl[i].e_busy, tbl[i].e_done}));
    end

    // FIFO full while a long command runs
    cycle(1'b1, 2'b01, 1'b0, '0, 8'd200, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 2'b10, 1'b0, '0, 8'd1, 1'b0, 1'b0, 1'b1);
      check("fill_ready", 32'(last_ready), 32'(1));
    end
    waits = 0;
    seen  = 0;
    for (int t = 0; t < 300 && !seen; t++) begin
      cycle(1'b1, 2'b11, 1'b0, '0, 8'd1, 1'b0, 1'b0, 1'b1);
      if (t == 0) check("full_not_ready", 32'(last_ready), 32'(0));
      if (last_ready) seen = 1; else waits++;
    end
    check("fifth_accept_wait", 32'(waits), 32'(196));
    for (int i = 0; i < 20; i++) idle(1'b1);
    check("drained", 32'(busy), 32'(0));

    // Abort mid-run flushes queue, no done
    cycle(1'b1, 2'b01, 1'b0, '0, 8'd50, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 2'b10, 1'b0, '0, 8'd5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) idle(1'b1);
    check("pre_abort_run", 32'({control, busy}), 32'({2'b01, 1'b1}));
    cycle(1'b1, 2'b11, 1'b0, '0, 8'd3, 1'b1, 1'b0, 1'b1);
    check("abort_ready", 32'(last_ready), 32'(0));
    check("abort_out", 32'({control, init, busy, done}), 32'(0));
    n_ok = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      if (!busy && !done && control == 2'b00) n_ok++;
    end
    check("abort_flushed", 32'(n_ok), 32'(4));

    // Zero length runs one cycle
    cycle(1'b1, 2'b10, 1'b0, '0, 8'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    check("len0_run", 32'({control, busy, done}), 32'({2'b10, 1'b1, 1'b0}));
    idle(1'b1);
    check("len0_done", 32'({control, busy, done}), 32'({2'b00, 1'b0, 1'b1}));

    // Asynchronous reset mid-run
    cycle(1'b1, 2'b01, 1'b1, 2'b10, 8'd20, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 2'b11, 1'b0, '0, 8'd4, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", 32'({control, init, initial_value, busy, done}), 32'(0));
    check("rst_mid_ready", 32'(cmd_ready), 32'(1));
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1'b1);
    idle(1'b1);
    check("rst_no_resume", 32'({busy, done}), 32'(0));

`ifdef SEQ_PAUSE_EN
    // Pause 5 cycles during RUN stretches it by 5 with control held at 00
    cycle(1'b1, 2'b01, 1'b0, '0, 8'd10, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    n_up = (control == 2'b01) ? 1 : 0;
    n_zero = 0;
    for (int i = 0; i < 2; i++) begin idle(1'b0); if (control == 2'b01) n_up++; end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 2'b00, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      if (control == 2'b00 && busy) n_zero++;
    end
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      idle(1'b0);
      if (done) seen = 1;
      else if (control == 2'b01) n_up++;
    end
    check("pause_run_cycles", 32'(n_up), 32'(10));
    check("pause_hold_cycles", 32'(n_zero), 32'(5));
    check("pause_done", 32'(seen), 32'(1));
    idle(1'b0);
    model_reset();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic ps;
`ifdef SEQ_PAUSE_EN
      ps = 1'b0;
`else
      ps = 1'($urandom_range(0, 1));
`endif
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            COUNTER_SIZE'($urandom), LEN_W'($urandom_range(0, 4)),
            ($urandom_range(0, 39) == 0), ps, 1'b1);
    end
    for (int i = 0; i < 40; i++) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
